// File: rtl/mul_pkg.sv
// Shared definitions for the pipelined Booth multiplier: operation encodings
// and the Booth group-count helper.
package mul_pkg;

    typedef enum logic [1:0] {
        MUL_OP_MUL  = 2'b00,
        MUL_OP_MADD = 2'b01,
        MUL_OP_MSUB = 2'b10
    } mul_op_e;

    // Radix-4 recoding of a (WIDTH+1)-bit multiplier padded to an even length.
    function automatic int mul_booth_groups(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_csa.sv
// Combinational Booth radix-4 partial-product generator with a carry-save
// reduction tree; the product is sum + carry modulo 2^(2*WIDTH).
module booth_csa
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               is_signed,
    output logic [2*WIDTH-1:0] sum,
    output logic [2*WIDTH-1:0] carry
);

    localparam int PW     = 2 * WIDTH;
    localparam int GROUPS = mul_booth_groups(WIDTH);

    logic              x_ext;
    logic              y_ext;
    logic [PW-1:0]     x_one;
    logic [PW-1:0]     x_two;
    logic [2*GROUPS:0] y_pad;
    logic [2:0]        grp;
    logic [PW-1:0]     pp;
    logic [PW-1:0]     s;
    logic [PW-1:0]     c;
    logic [PW-1:0]     maj;

    assign x_ext = is_signed & x[WIDTH-1];
    assign y_ext = is_signed & y[WIDTH-1];
    assign x_one = {{WIDTH{x_ext}}, x};
    assign x_two = {x_one[PW-2:0], 1'b0};
    assign y_pad = {y_ext, y_ext, y, 1'b0};

    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        s   = '0;
        c   = '0;
        grp = '0;
        pp  = '0;
        maj = '0;
        // Negative digits are one's-complemented; their +1 lands in the carry vector.
        for (int j = 0; j < GROUPS; j++) begin
            grp      = y_pad[2*j +: 3];
            c[2*j]   = grp[2] & ~(grp[1] & grp[0]);
        end
        // NOTE: blocking assignments here chain each 3:2 stage into the next.
        for (int j = 0; j < GROUPS; j++) begin
            grp = y_pad[2*j +: 3];
            case (grp)
                3'b001, 3'b010: pp = x_one;
                3'b101, 3'b110: pp = ~x_one;
                3'b011:         pp = x_two;
                3'b100:         pp = ~x_two;
                default:        pp = '0;
            endcase
            pp  = pp << (2 * j);
            maj = (s & c) | (s & pp) | (c & pp);
            s   = s ^ c ^ pp;
            c   = {maj[PW-2:0], 1'b0};
        end
        sum   = s;
        carry = c;
    end

endmodule

// File: rtl/mul_pipe.sv
// Pipelined Booth/CSA multiplier with MADD/MSUB, valid/ready back-pressure
// and flush; all stages advance together on en.
module mul_pipe
    import mul_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter bit ACC_EN = 1'b1
) (
    input  logic               mul_clk,
    input  logic               resetn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [1:0]         in_op,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result
);

    localparam int PW = 2 * WIDTH;

    typedef struct packed {
        logic [PW-1:0] sum;
        logic [PW-1:0] carry;
        mul_op_e       op;
        logic [PW-1:0] acc;
    } stage_t;

    logic            en;
    logic            accept;
    logic [PW-1:0]   pp_sum;
    logic [PW-1:0]   pp_carry;
    logic [PW-1:0]   prod;
    logic [PW-1:0]   final_val;
    mul_op_e         op_norm;
    stage_t          entry;
    stage_t          pipe [1:STAGES-1];
    logic [STAGES-1:1] vld;

    booth_csa #(.WIDTH(WIDTH)) u_booth (
        .x         (x),
        .y         (y),
        .is_signed (in_signed),
        .sum       (pp_sum),
        .carry     (pp_carry)
    );

    assign en       = !out_valid || out_ready;
    assign in_ready = en && !flush && resetn;
    assign accept   = in_valid && in_ready;

    // Reserved encodings and accumulate ops without ACC_EN collapse to MUL.
    always_comb begin
        op_norm = MUL_OP_MUL;
        if (ACC_EN) begin
            case (in_op)
                MUL_OP_MADD: op_norm = MUL_OP_MADD;
                MUL_OP_MSUB: op_norm = MUL_OP_MSUB;
                default:     op_norm = MUL_OP_MUL;
            endcase
        end
    end

    always_comb begin
        entry.sum   = pp_sum;
        entry.carry = pp_carry;
        entry.op    = op_norm;
        entry.acc   = ACC_EN ? acc_in : '0;
    end

    always_comb begin
        prod = pipe[STAGES-1].sum + pipe[STAGES-1].carry;
        case (pipe[STAGES-1].op)
            MUL_OP_MADD: final_val = pipe[STAGES-1].acc + prod;
            MUL_OP_MSUB: final_val = pipe[STAGES-1].acc - prod;
            default:     final_val = prod;
        endcase
    end

    always_ff @(posedge mul_clk) begin
        if (!resetn) begin
            // NOTE: payload registers are cleared too, so reset leaves no stale data.
            vld       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            for (int k = 1; k < STAGES; k++) begin
                pipe[k] <= '0;
            end
        end else if (flush) begin
            vld       <= '0;
            out_valid <= 1'b0;
        end else if (en) begin
            vld[1]  <= accept;
            pipe[1] <= entry;
            for (int k = 2; k < STAGES; k++) begin
                vld[k]  <= vld[k-1];
                pipe[k] <= pipe[k-1];
            end
            out_valid <= vld[STAGES-1];
            // Bubbles leave the last delivered result untouched.
            if (vld[STAGES-1]) begin
                result <= final_val;
            end
        end
    end

endmodule
